// File: rtl/multicycle_controller.sv
// Per-state control sequencer for the multicycle RV32I core.
// Outputs are decoded from the current state; memory states hand-shake on mem_ready.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUbit31,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned OPW = 7;

  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_R      = 7'b0110011;
  localparam logic [OPW-1:0] OP_I      = 7'b0010011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Branch condition from funct3 and the ALU flags of the rs1-rs2 compare.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:          w_taken = Zero;
      3'b001:          w_taken = ~Zero;
      3'b100, 3'b110:  w_taken = ALUbit31;
      3'b101, 3'b111:  w_taken = ~ALUbit31;
      default:         w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    ImmSrc       = 3'b000;
    ResultSrc    = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    state        = 4'(r_state);

    case (r_state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_R:              w_next_state = S_EXECR;
          OP_I:              w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
          OP_AUIPC:          w_next_state = S_AUIPC;
          default:           w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_STORE) begin
          ImmSrc       = 3'b001;
          w_next_state = S_MEMWRITE;
        end else begin
          w_next_state = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite     = 1'b1;
        ResultSrc    = 2'b01;
        instr_done   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ALUOp        = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        PCWrite      = w_taken;
        instr_done   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        PCWrite      = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        PCWrite      = 1'b1;
        w_next_state = S_LINK;
      end
      S_LINK: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_LUI: begin
        RegWrite     = 1'b1;
        ImmSrc       = 3'b100;
        ResultSrc    = 2'b11;
        instr_done   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b01;
        ImmSrc       = 3'b100;
        w_next_state = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal      = 1'b1;
        w_next_state = S_ILLEGAL;
      end
      default: w_next_state = S_ILLEGAL;
    endcase

    // Reset silences every output immediately, before the state register settles.
    if (reset) begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      ImmSrc     = 3'b000;
      ResultSrc  = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state      = 4'd0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle variant of the RV32I core. It drives the shared ALU, the instruction/data memory port, the IR, the PC and the register file one step per cycle. It replaces the single-cycle decoder's one-shot control word with per-state control and a ready/request handshake to a memory that may stall. It sits between the IR fields (opcode, funct3), the ALU flags and the datapath muxes/enables.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  IR[6:0]; stable from the cycle after IRWrite
- funct3  in  3  IR[14:12]
- Zero  in  1  ALU result == 0
- ALUbit31  in  1  ALU sign/compare bit
- mem_ready  in  1  memory completes the current request this cycle
- MemRead / MemWrite  out  1  memory request, held until mem_ready
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- IRWrite  out  1  latch instruction and OldPC
- PCWrite  out  1  PC <= Result
- RegWrite  out  1  regfile write
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 (A reg)
- ALUSrcB  out  2  00 rs2 (B reg), 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 ImmExt
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  unknown opcode trapped; sticky until reset
- state  out  4  current state, for debug

## Operation
- All outputs are 0 unless listed. Outputs are decoded from state. PCWrite, IRWrite and instr_done are also gated by the mem_ready and branch terms below.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, LUI 13, AUIPC 14, ILLEGAL 15.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when mem_ready=1; then go to DECODE.
  - When mem_ready=0, stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which produces the branch/jal target in ALUOut. ImmSrc=011 if opcode is 1101111, else 010. Next state by opcode:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. ImmSrc=001 for a store, 000 for a load. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, instr_done=1, then -> FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. Wait for mem_ready; on that cycle instr_done=1, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10, then -> ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, instr_done=1, then -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1, then -> FETCH.
  - PCWrite equals the taken condition for funct3:
  - 000 Zero; 001 !Zero
  - 100 and 110 ALUbit31; 101 and 111 !ALUbit31
  - 010 and 011 never taken
- JAL: PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut <= OldPC+4), then -> ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00, ResultSrc=10, PCWrite=1, then -> LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00, then -> ALUWB.
- LUI: RegWrite=1, ImmSrc=100, ResultSrc=11, instr_done=1, then -> FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100, ALUOp=00, then -> ALUWB.
- ILLEGAL: illegal=1, no enables asserted, absorbing until reset.

## Timing
- While reset=1: state=FETCH, illegal=0, and every output is forced to 0.
- The first cycle after reset release is FETCH with MemRead=1.
- Instruction latency in cycles with zero-wait memory; each stalled memory cycle adds 1:
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - lui: 3
  - auipc: 4
- Handshake rules:
  - MemRead/MemWrite and AdrSrc are held constant while waiting.
  - The request drops in the cycle after mem_ready.
  - mem_ready outside a memory state is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial enables are asserted after the asynchronous edge.

## Test plan
- Reset release, then addi (0010011) with mem_ready tied 1 -> states 0,1,7,8,0. PCWrite/IRWrite pulse in cycle 1; RegWrite and instr_done in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD -> MemRead=1 and AdrSrc=1 held 4 cycles; MEMWB follows; total 8 cycles.
- beq with Zero=1, then bne with Zero=1 -> PCWrite=1 in BRANCH for the first, 0 for the second; both take 3 cycles.
- jalr -> PCWrite with ResultSrc=10 in JALR, then LINK (ALUSrcA=01, ALUSrcB=10), then ALUWB with RegWrite=1.
- opcode 7'b1111111 -> ILLEGAL; illegal=1 stays high through 20 cycles; reset clears it and returns to FETCH.
- Assert reset during MEMWRITE with mem_ready=0 -> MemWrite drops to 0 in the same cycle as the reset edge and state=0.
